// File: rtl/not8_arbiter.sv
// Round-robin arbiter that shares one 8-bit inverter between four requesters.
// Returns the winner's inverted operand and its ID over a valid/ready output.
module not8bit (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  assign y_o = ~a_i;
endmodule

module not8_arbiter #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] din,
  input  logic                     out_ready,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     out_valid,
  output logic [1:0]               out_id,
  output logic [WIDTH-1:0]         result,
  output logic                     busy,
  output logic [1:0]               dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               out_valid_q, out_valid_d;
  logic [1:0]         out_id_q, out_id_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   operand_q, operand_d;
  logic [1:0]         ptr_q, ptr_d;

  logic               win_found;
  logic [1:0]         win_id;
  logic [1:0]         cand_idx;
  logic [WIDTH-1:0]   inv_y;

  not8bit u_not8bit (
    .a_i (operand_q),
    .y_o (inv_y)
  );

  // Scan ptr+1, ptr+2, ptr+3, ptr; first requester found wins.
  always_comb begin
    win_found = 1'b0;
    win_id    = 2'd0;
    cand_idx  = 2'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_idx = ptr_q + 2'(k);
      if (!win_found && req[cand_idx]) begin
        win_found = 1'b1;
        win_id    = cand_idx;
      end
    end
  end

  // Output handshake: a result transfers on a rising edge where out_valid and
  // out_ready are both high; until then result, out_id and gnt stay frozen.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    out_valid_d = out_valid_q;
    out_id_d    = out_id_q;
    result_d    = result_q;
    operand_d   = operand_q;
    ptr_d       = ptr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d     = NUM_REQ'(1) << win_id;
          operand_d = din[win_id*WIDTH +: WIDTH];
          out_id_d  = win_id;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        result_d    = inv_y;
        out_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          gnt_d       = '0;
          ptr_d       = out_id_q;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        gnt_d       = '0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= 2'd0;
      result_q    <= '0;
      operand_q   <= '0;
      ptr_q       <= 2'd3;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      result_q    <= result_d;
      operand_q   <= operand_d;
      ptr_q       <= ptr_d;
    end
  end

  assign gnt         = gnt_q;
  assign out_valid   = out_valid_q;
  assign out_id      = out_id_q;
  assign result      = result_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_not8_arbiter.sv
// Bench for not8_arbiter: directed vectors, expected results queued by the
// driver and popped by a monitor on each output handshake.
module tb_not8_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] din;
  logic        out_ready;
  logic [3:0]  gnt;
  logic        out_valid;
  logic [1:0]  out_id;
  logic [7:0]  result;
  logic        busy;
  logic [1:0]  dbg_state;

  int total;
  int bad;
  logic [9:0] exp_q[$];

  not8_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .din         (din),
    .out_ready   (out_ready),
    .gnt         (gnt),
    .out_valid   (out_valid),
    .out_id      (out_id),
    .result      (result),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: busy=%0b expected 0", busy);
    end
  endtask

  function automatic logic [9:0] pack(input logic [1:0] id, input logic [7:0] op);
    logic [7:0] inv;
    inv = ~op;
    return {id, inv};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
      logic [9:0] e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got id=%0d res=%0h expected none", out_id, result);
      end else begin
        e = exp_q.pop_front();
        if ({out_id, result} !== e) begin
          bad++;
          $display("FAIL sb_result: got id=%0d res=%0h expected id=%0d res=%0h",
                   out_id, result, e[9:8], e[7:0]);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1; req = '0; din = '0; out_ready = 1'b0;
    total = 0; bad = 0;

    // 1. reset mid-cycle, no clock edge
    #3;
    rst_n = 1'b0;
    #1;
    check("t1_gnt", {28'd0, gnt}, 32'd0);
    check("t1_valid", {31'd0, out_valid}, 32'd0);
    check("t1_id", {30'd0, out_id}, 32'd0);
    check("t1_result", {24'd0, result}, 32'd0);
    check("t1_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    step(); step(); step();
    check("t1_busy_after", {31'd0, busy}, 32'd0);

    // 2. single request
    req = 4'b0001; din = 32'h0; out_ready = 1'b1;
    exp_q.push_back(pack(2'd0, 8'h00));
    step();
    check("t2_gnt", {28'd0, gnt}, 32'h1);
    check("t2_state_exec", {30'd0, dbg_state}, 32'h1);
    req = 4'b0000;
    step();
    check("t2_valid", {31'd0, out_valid}, 32'h1);
    check("t2_result", {24'd0, result}, 32'hFF);
    step();
    check("t2_idle", {31'd0, busy}, 32'd0);
    check("t2_gnt_clr", {28'd0, gnt}, 32'd0);

    // 3. all four at once
    do_reset();
    req = 4'b1111; din = 32'hFF12_3CAA; out_ready = 1'b1;
    exp_q.push_back(pack(2'd0, 8'hAA));
    exp_q.push_back(pack(2'd1, 8'h3C));
    exp_q.push_back(pack(2'd2, 8'h12));
    exp_q.push_back(pack(2'd3, 8'hFF));
    for (int i = 0; i < 4; i++) begin
      step();
      check("t3_gnt", {28'd0, gnt}, 32'd1 << i);
      if (i == 3) req = 4'b0000;
      step(); step();
    end
    wait_idle();

    // 4. fairness with req0 and req2 held
    do_reset();
    req = 4'b0101; din = 32'h00F0_000F; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) exp_q.push_back(pack(2'd0, 8'h0F));
      else            exp_q.push_back(pack(2'd2, 8'hF0));
    end
    for (int i = 0; i < 6; i++) begin
      step();
      check("t4_gnt", {28'd0, gnt}, (i % 2 == 0) ? 32'h1 : 32'h4);
      if (i == 5) req = 4'b0000;
      step(); step();
    end
    wait_idle();

    // 5. backpressure
    do_reset();
    req = 4'b0010; din = 32'h0000_8100; out_ready = 1'b0;
    exp_q.push_back(pack(2'd1, 8'h81));
    step(); step();
    for (int i = 0; i < 5; i++) begin
      din = {$urandom_range(0, 65535), $urandom_range(0, 65535)};
      req = 4'($urandom_range(0, 15));
      step();
      check("t5_result", {24'd0, result}, 32'h7E);
      check("t5_id", {30'd0, out_id}, 32'h1);
      check("t5_gnt", {28'd0, gnt}, 32'h2);
      check("t5_valid", {31'd0, out_valid}, 32'h1);
    end
    req = 4'b0101; din = 32'h0033_0000; out_ready = 1'b1;
    exp_q.push_back(pack(2'd2, 8'h33));
    step();
    check("t5_gnt_release", {28'd0, gnt}, 32'd0);
    step();
    check("t5_gnt_next", {28'd0, gnt}, 32'h4);
    req = 4'b0000;
    wait_idle();

    // 6. reset while in RESP
    do_reset();
    req = 4'b0100; din = 32'h0055_0000; out_ready = 1'b0;
    step(); step();
    check("t6_id_before", {30'd0, out_id}, 32'h2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_valid_clr", {31'd0, out_valid}, 32'd0);
    check("t6_gnt_clr", {28'd0, gnt}, 32'd0);
    check("t6_result_clr", {24'd0, result}, 32'd0);
    check("t6_busy_clr", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0101; din = 32'h0000_0001; out_ready = 1'b1;
    exp_q.push_back(pack(2'd0, 8'h01));
    step();
    check("t6_gnt", {28'd0, gnt}, 32'h1);
    req = 4'b0000;
    wait_idle();
    step(); step();

    check("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
